// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - controller FSM states, loop defaults and loop config type
package ctrl;

    localparam int LOOP_TAPS_W  = 8;
    localparam int LOOP_STAGE_W = 3;
    localparam int LOOP_VEC_W   = 4;
    localparam int LOOP_ADDR_W  = 10;

    localparam int DEF_TAPS    = 15;
    localparam int DEF_STAGES  = 1;
    localparam int DEF_VECTORS = 3;

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4,
        S5 = 4'd5,
        S6 = 4'd6,
        S7 = 4'd7,
        S8 = 4'd8
    } fsmState_e;

    typedef struct packed {
        logic [LOOP_TAPS_W-1:0]  taps;
        logic [LOOP_STAGE_W-1:0] stages;
        logic [LOOP_VEC_W-1:0]   vectors;
    } loopCfg_t;

endpackage

// File: rtl/ctrl_loop_sequencer_if.sv
// rtl/ctrl_loop_sequencer_if.sv - FSM/config/datapath bundle of the loop sequencer
interface ctrl_loop_sequencer_if
    import ctrl::*;
#(
    parameter int TAPS_W  = ctrl::LOOP_TAPS_W,
    parameter int STAGE_W = ctrl::LOOP_STAGE_W,
    parameter int VEC_W   = ctrl::LOOP_VEC_W,
    parameter int ADDR_W  = ctrl::LOOP_ADDR_W
);
    logic               en;
    fsmState_e          state;
    logic               cfg_load;
    logic [TAPS_W-1:0]  cfg_taps;
    logic [STAGE_W-1:0] cfg_stages;
    logic [VEC_W-1:0]   cfg_vectors;
    logic               vector_pass;
    logic               last_stage;
    logic               last_vector;
    logic               mac_clr;
    logic               mac_en;
    logic [ADDR_W-1:0]  coef_addr;
    logic [ADDR_W-1:0]  data_addr;
    logic               cfg_pending;

    modport master (
        output en, state, cfg_load, cfg_taps, cfg_stages, cfg_vectors,
        input  vector_pass, last_stage, last_vector, mac_clr, mac_en,
               coef_addr, data_addr, cfg_pending
    );

    modport slave (
        input  en, state, cfg_load, cfg_taps, cfg_stages, cfg_vectors,
        output vector_pass, last_stage, last_vector, mac_clr, mac_en,
               coef_addr, data_addr, cfg_pending
    );
endinterface

// File: rtl/ctrl_cfg_shadow.sv
// rtl/ctrl_cfg_shadow.sv - double-buffered loop config with pending flag
module ctrl_cfg_shadow
    import ctrl::*;
#(
    parameter int DEF_TAPS    = ctrl::DEF_TAPS,
    parameter int DEF_STAGES  = ctrl::DEF_STAGES,
    parameter int DEF_VECTORS = ctrl::DEF_VECTORS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     load,
    input  loopCfg_t cfg_in,
    input  logic     apply,
    output loopCfg_t active,
    output logic     pending
);
    localparam loopCfg_t RST_CFG = '{
        taps:    LOOP_TAPS_W'(DEF_TAPS),
        stages:  LOOP_STAGE_W'(DEF_STAGES),
        vectors: LOOP_VEC_W'(DEF_VECTORS)
    };

    loopCfg_t active_q, active_d;
    loopCfg_t shadow_q, shadow_d;
    logic     pending_q, pending_d;

    // Apply consumes the old shadow; a same-cycle load re-arms pending with the new one.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (apply && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = cfg_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_q  <= RST_CFG;
            shadow_q  <= RST_CFG;
            pending_q <= 1'b0;
        end else if (en) begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign active  = active_q;
    assign pending = pending_q;
endmodule

// File: rtl/ctrl_loop_sequencer.sv
// rtl/ctrl_loop_sequencer.sv - tap/stage/vector counters and RAM address generation
module ctrl_loop_sequencer
    import ctrl::*;
#(
    parameter int TAPS_W      = ctrl::LOOP_TAPS_W,
    parameter int STAGE_W     = ctrl::LOOP_STAGE_W,
    parameter int VEC_W       = ctrl::LOOP_VEC_W,
    parameter int ADDR_W      = ctrl::LOOP_ADDR_W,
    parameter int DEF_TAPS    = ctrl::DEF_TAPS,
    parameter int DEF_STAGES  = ctrl::DEF_STAGES,
    parameter int DEF_VECTORS = ctrl::DEF_VECTORS
) (
    input logic                  clk,
    input logic                  rst,
    ctrl_loop_sequencer_if.slave bus
);
    logic [TAPS_W-1:0]  tap_cnt_q, tap_cnt_d;
    logic [STAGE_W-1:0] stage_cnt_q, stage_cnt_d;
    logic [VEC_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [ADDR_W-1:0]  coef_base_q, coef_base_d;
    logic [ADDR_W-1:0]  data_ptr_q, data_ptr_d;

    loopCfg_t          act_cfg;
    loopCfg_t          cfg_in;
    logic              vector_pass, last_stage, last_vector, frame_wrap;
    logic [ADDR_W-1:0] coef_step;

    assign cfg_in = '{taps: bus.cfg_taps, stages: bus.cfg_stages, vectors: bus.cfg_vectors};

    ctrl_cfg_shadow #(
        .DEF_TAPS    (DEF_TAPS),
        .DEF_STAGES  (DEF_STAGES),
        .DEF_VECTORS (DEF_VECTORS)
    ) u_cfg_shadow (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .load    (bus.cfg_load),
        .cfg_in  (cfg_in),
        .apply   (frame_wrap),
        .active  (act_cfg),
        .pending (bus.cfg_pending)
    );

    assign vector_pass = (bus.state == S3) && (tap_cnt_q == act_cfg.taps);
    assign last_stage  = (stage_cnt_q == act_cfg.stages);
    assign last_vector = (vec_cnt_q == act_cfg.vectors);
    assign frame_wrap  = (bus.state == S8) && last_stage && last_vector;
    assign coef_step   = ADDR_W'(act_cfg.taps) + ADDR_W'(1);

    always_comb begin
        tap_cnt_d   = tap_cnt_q;
        stage_cnt_d = stage_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        coef_base_d = coef_base_q;
        data_ptr_d  = data_ptr_q;
        case (bus.state)
            S2: tap_cnt_d = '0;
            S3: if (!vector_pass) tap_cnt_d = tap_cnt_q + TAPS_W'(1);
            S7: data_ptr_d = data_ptr_q + ADDR_W'(1);
            S8: begin
                if (!last_stage) begin
                    stage_cnt_d = stage_cnt_q + STAGE_W'(1);
                    coef_base_d = coef_base_q + coef_step;
                end else if (!last_vector) begin
                    stage_cnt_d = '0;
                    vec_cnt_d   = vec_cnt_q + VEC_W'(1);
                    coef_base_d = coef_base_q + coef_step;
                end else begin
                    stage_cnt_d = '0;
                    vec_cnt_d   = '0;
                    coef_base_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tap_cnt_q   <= '0;
            stage_cnt_q <= '0;
            vec_cnt_q   <= '0;
            coef_base_q <= '0;
            data_ptr_q  <= '0;
        end else if (bus.en) begin
            tap_cnt_q   <= tap_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            coef_base_q <= coef_base_d;
            data_ptr_q  <= data_ptr_d;
        end
    end

    assign bus.vector_pass = vector_pass;
    assign bus.last_stage  = last_stage;
    assign bus.last_vector = last_vector;
    assign bus.mac_clr     = (bus.state == S2);
    assign bus.mac_en      = (bus.state == S3);
    // Zero-latency addresses; data_addr wraps naturally as a circular buffer index.
    assign bus.coef_addr   = coef_base_q + ADDR_W'(tap_cnt_q);
    assign bus.data_addr   = data_ptr_q + ADDR_W'(tap_cnt_q);
endmodule

// File: tb/tb_ctrl_loop_sequencer.sv
// tb/tb_ctrl_loop_sequencer.sv - directed and random checks against a loop-count model
module tb_ctrl_loop_sequencer;
    import ctrl::*;

    localparam int AMOD = 1024;
    localparam int TMOD = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_loop_sequencer_if #(.TAPS_W(8), .STAGE_W(3), .VEC_W(4), .ADDR_W(10)) bus();

    ctrl_loop_sequencer #(
        .TAPS_W(8), .STAGE_W(3), .VEC_W(4), .ADDR_W(10),
        .DEF_TAPS(15), .DEF_STAGES(1), .DEF_VECTORS(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: loop position, frame-relative coefficient base, buffer pointer, configs.
    int m_tap, m_stage, m_vec, m_coef, m_ptr;
    int a_taps, a_st, a_vec;
    int s_taps, s_st, s_vec;
    bit m_pend;

    logic       obs_vp, obs_ls, obs_lv, obs_pend;
    logic [9:0] obs_coef, obs_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tap = 0; m_stage = 0; m_vec = 0; m_coef = 0; m_ptr = 0;
        a_taps = DEF_TAPS; a_st = DEF_STAGES; a_vec = DEF_VECTORS;
        m_pend = 1'b0;
    endtask

    task automatic step(input fsmState_e s, input bit e = 1'b1, input bit ld = 1'b0,
                        input int ct = 0, input int cs = 0, input int cv = 0, input bit r = 1'b1);
        @(negedge clk);
        rst             = r;
        bus.en          = e;
        bus.state       = s;
        bus.cfg_load    = ld;
        bus.cfg_taps    = ct[7:0];
        bus.cfg_stages  = cs[2:0];
        bus.cfg_vectors = cv[3:0];
        #1;
        chk("vector_pass", bus.vector_pass, (s == S3) && (m_tap == a_taps));
        chk("last_stage",  bus.last_stage,  m_stage == a_st);
        chk("last_vector", bus.last_vector, m_vec == a_vec);
        chk("mac_clr",     bus.mac_clr,     s == S2);
        chk("mac_en",      bus.mac_en,      s == S3);
        chk("coef_addr",   bus.coef_addr,   (m_coef + m_tap) % AMOD);
        chk("data_addr",   bus.data_addr,   (m_ptr + m_tap) % AMOD);
        chk("cfg_pending", bus.cfg_pending, m_pend);
        obs_vp = bus.vector_pass; obs_ls = bus.last_stage; obs_lv = bus.last_vector;
        obs_pend = bus.cfg_pending; obs_coef = bus.coef_addr; obs_data = bus.data_addr;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (e) begin
            case (s)
                S2: m_tap = 0;
                S3: if (m_tap != a_taps) m_tap = (m_tap + 1) % TMOD;
                S7: m_ptr = (m_ptr + 1) % AMOD;
                S8: begin
                    if (m_stage != a_st) begin
                        m_stage++;
                        m_coef = (m_coef + a_taps + 1) % AMOD;
                    end else if (m_vec != a_vec) begin
                        m_stage = 0;
                        m_vec++;
                        m_coef = (m_coef + a_taps + 1) % AMOD;
                    end else begin
                        m_stage = 0; m_vec = 0; m_coef = 0;
                        if (m_pend) begin
                            a_taps = s_taps; a_st = s_st; a_vec = s_vec;
                            m_pend = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (ld) begin
                s_taps = ct % TMOD; s_st = cs % 8; s_vec = cv % 16;
                m_pend = 1'b1;
            end
        end
    endtask

    // One convolution as the FSM runs it: S2, then S3 until vector_pass is seen.
    task automatic conv(output int dwell);
        step(S2);
        dwell = 0;
        do begin
            step(S3);
            dwell++;
        end while (!obs_vp && dwell < 300);
    endtask

    task automatic peek_base();
        step(S2);
        step(S1);
    endtask

    initial begin
        int d;
        logic [9:0] da [4];
        bus.en = 1'b1; bus.state = S0; bus.cfg_load = 1'b0;
        bus.cfg_taps = '0; bus.cfg_stages = '0; bus.cfg_vectors = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        s_taps = DEF_TAPS; s_st = DEF_STAGES; s_vec = DEF_VECTORS;

        step(S0);
        chk("reset_coef", obs_coef, 0);
        chk("reset_pend", obs_pend, 0);
        chk("reset_last_stage", obs_ls, 0);

        step(S1);
        conv(d);
        chk("dwell_default", d, 16);

        step(S8);
        peek_base();
        chk("coef_base_16", obs_coef, 16);
        chk("last_stage_after_s8", obs_ls, 1);
        step(S8);
        peek_base();
        chk("coef_base_32", obs_coef, 32);
        chk("stage_back_to_0", obs_ls, 0);

        for (int i = 0; i < 6; i++) begin
            conv(d);
            chk("dwell_pre_wrap", d, 16);
            step(S4);
            step(S5, 1'b1, i == 2, 7, 1, 3);
            step(S6);
            if (i >= 2) chk("pending_mid_frame", obs_pend, 1);
            if (i == 5) chk("last_vector_before_wrap", obs_lv, 1);
            step(S7);
            step(S8);
        end
        peek_base();
        chk("wrap_coef_base", obs_coef, 0);
        chk("wrap_pending_cleared", obs_pend, 0);
        conv(d);
        chk("dwell_new_cfg", d, 8);

        step(S1, 1'b1, 1'b1, 3, 0, 0);
        repeat (8) step(S8);
        step(S1);
        chk("taps3_applied_pending", obs_pend, 0);
        for (int k = 0; k < 2000 && m_ptr != 1022; k++) step(S7);
        step(S2);
        for (int k = 0; k < 4; k++) begin
            step(S3);
            da[k] = obs_data;
        end
        chk("wrap_addr0", da[0], 1022);
        chk("wrap_addr1", da[1], 1023);
        chk("wrap_addr2", da[2], 0);
        chk("wrap_addr3", da[3], 1);
        chk("taps3_vp_last", obs_vp, 1);
        step(S7);
        peek_base();
        chk("data_ptr_1023", obs_data, 1023);

        for (int k = 0; k < 400; k++) begin
            step(fsmState_e'($urandom_range(0, 8)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 255),
                 $urandom_range(0, 7), $urandom_range(0, 15));
        end

        step(S0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        step(S1, 1'b1, 1'b1, 5, 0, 0);
        step(S2);
        repeat (9) step(S3);
        step(S3, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("tap9_before_reset", obs_coef, 9);
        step(S1);
        chk("reset_tap_cleared", obs_coef, 0);
        chk("reset_pending_lost", obs_pend, 0);
        conv(d);
        chk("dwell_after_reset", d, 16);
        step(S3, 1'b0);
        step(S7, 1'b0);
        step(S8, 1'b0);
        step(S2, 1'b0);
        step(S3, 1'b0);
        chk("frozen_coef", obs_coef, 15);
        chk("frozen_data", obs_data, 15);
        step(S1);
        chk("frozen_coef_after", obs_coef, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
